axil_reg_slave: RTL and testbench
=================================

# axil_reg_slave

AXI4-Lite slave register bank that terminates the write-address, write-data, write-response, read-address and read-data channels driven by the AXI master in the waveform encoder. It holds sixteen 32-bit control/status registers, answers each write with a B response and each read with an R beat, and supports byte-lane writes through the write strobe. It sits directly downstream of the master on the same `ACLK` domain.

## Interface
- `WIDTH`, 32: address and data width in bits; only 32 is supported.
- `BASE_ADDR`, 32'h0000_1000: byte base address of the bank; must be 64-byte aligned.
- `ID_VALUE`, 32'h4E45_0001: constant returned by register 0.
- `ACLK` in 1: single clock, all logic rising-edge.
- `ARESETn` in 1: reset, synchronous, active-low.
- `AWVALID` in 1 / `AWREADY` out 1 / `AWADDR` in WIDTH: write-address channel.
- `WVALID` in 1 / `WREADY` out 1 / `WDATA` in WIDTH / `WSTRB` in WIDTH/8: write-data channel.
- `BVALID` out 1 / `BREADY` in 1 / `BRESP` out 2: write-response channel.
- `ARVALID` in 1 / `ARREADY` out 1 / `ARADDR` in WIDTH: read-address channel.
- `RVALID` out 1 / `RREADY` in 1 / `RDATA` out WIDTH / `RRESP` out 2: read-data channel.

## Operation
- Register index = `ADDR[5:2]`; `ADDR[1:0]` ignored. Register 0 is read-only `ID_VALUE`; writes to it are discarded and respond OKAY. Registers 1–15 are read/write and reset to 0.
- Write FSM states: `WR_IDLE`, `WR_ADDR` (address held, waiting for data), `WR_DATA` (data held, waiting for address), `WR_RESP`.
  - `WR_IDLE`: `AWREADY`=`WREADY`=1. AW only → `WR_ADDR`; W only → `WR_DATA`; both in the same cycle → `WR_RESP`.
  - `WR_ADDR`: only `WREADY`=1; W handshake → `WR_RESP`. `WR_DATA`: only `AWREADY`=1; AW handshake → `WR_RESP`.
  - The register update happens on the edge entering `WR_RESP`; bytes with `WSTRB[i]`=0 are unchanged.
  - `WR_RESP`: `BVALID`=1, `BRESP` stable, both readys 0; `BVALID && BREADY` → `WR_IDLE`.
- Read FSM states: `RD_IDLE` (`ARREADY`=1) and `RD_DATA` (`RVALID`=1, `ARREADY`=0). AR handshake latches `RDATA`/`RRESP` from the register array and moves to `RD_DATA`. `RVALID && RREADY` → `RD_IDLE`.
- Read and write FSMs are independent. If a read latch and a write commit hit the same register on the same edge, the read returns the pre-write value.
- Once asserted, `BVALID`/`RVALID` and their payloads hold until the handshake completes. The slave never waits on the master's ready before asserting its own valid.

## Timing
- Reset values: `AWREADY`, `WREADY`, `ARREADY`, `BVALID`, `RVALID` = 0; `BRESP`, `RRESP`, `RDATA` = 0. All readys go to 1 on the first edge after `ARESETn` samples high.
- Write latency: the final AW/W handshake is at edge N, `BVALID` is 1 in cycle N+1, and the written value is readable by an AR at edge N+1 or later.
- Read latency: AR handshake at edge N, `RVALID` is 1 with data in cycle N+1.
- Back-to-back: after B/R completes at edge M, the ready is 1 again in cycle M+1. Throughput is one transaction per 2 cycles per direction.
- All ready/valid outputs are registered (state decode of flops); there is no combinational input-to-output path.
- Reset mid-operation: pending transactions are dropped, both FSMs return to idle, and registers 1–15 clear to 0.

## Configuration
- `AXIL_SLV_ERR_EN` defined: addresses with `ADDR[WIDTH-1:6] != BASE_ADDR[WIDTH-1:6]` respond SLVERR (2'b10). For such writes no register changes; for such reads `RDATA`=0. In-range accesses respond OKAY.
- `AXIL_SLV_ERR_EN` undefined: upper address bits are ignored, the bank aliases every 64 bytes, and every response is OKAY (2'b00).

## Structure
- Shared package `axil_pkg`:
  - `RESP_OKAY`/`RESP_EXOKAY`/`RESP_SLVERR`/`RESP_DECERR` constants.
  - The `axil_resp_t` 2-bit typedef.
  - Write and read FSM state typedefs.
  - `AXIL_NUM_REGS`=16.
- One sub-module, `axil_reg_array`: 16×32 storage with byte-strobed write port, asynchronous read port, constant register 0, and synchronous clear. Both FSMs stay in `axil_reg_slave`.

## Test plan
- Reset, then read register 0 → `RVALID` one cycle after AR, `RDATA`=32'h4E45_0001, `RRESP`=00; then read register 5 → 0.
- AW and W in the same cycle at `BASE_ADDR`+0x14 with data 32'hDEAD_BEEF and `WSTRB`=4'hF → `BVALID` next cycle with OKAY; a read of 0x14 returns 32'hDEAD_BEEF.
- W issued 3 cycles before AW with data 32'h1122_3344 and `WSTRB`=4'b0101 over a register holding 32'hAABB_CCDD → register reads 32'hAA22_CC44.
- Hold `BREADY`/`RREADY` low for 5 cycles → `BVALID`/`RVALID` and payload stay stable, and no new AW/W/AR is accepted.
- Read and write to register 7 commit on the same edge (old 0, new 32'h5) → R returns 0 and the next read returns 32'h5.
- With `AXIL_SLV_ERR_EN`: write 32'h1 to 32'h0000_2004 → `BRESP`=10 and register 1 stays unchanged. Without the macro, the same write → `BRESP`=00 and register 1 reads 1.

Source files
------------

// File: rtl/axil_pkg.sv
// Shared AXI4-Lite definitions for the register slave: response codes,
// FSM state types and register-bank geometry.
package axil_pkg;

  localparam int unsigned AXIL_NUM_REGS = 16;
  localparam int unsigned AXIL_IDX_W    = 4;

  typedef logic [1:0] axil_resp_t;

  localparam axil_resp_t RESP_OKAY   = 2'b00;
  localparam axil_resp_t RESP_EXOKAY = 2'b01;
  localparam axil_resp_t RESP_SLVERR = 2'b10;
  localparam axil_resp_t RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {
    WR_IDLE = 2'd0,
    WR_ADDR = 2'd1,
    WR_DATA = 2'd2,
    WR_RESP = 2'd3
  } wr_state_e;

  typedef enum logic {
    RD_IDLE = 1'b0,
    RD_DATA = 1'b1
  } rd_state_e;

endpackage

// File: rtl/axil_reg_slave_if.sv
// AXI4-Lite bundle (AW, W, B, AR, R channels) between master and slave.
// Modports: master drives valids/addr/data/readys of B,R; slave the rest.
interface axil_reg_slave_if #(
  parameter int unsigned WIDTH = 32
) ();

  logic               AWVALID;
  logic               AWREADY;
  logic [WIDTH-1:0]   AWADDR;
  logic               WVALID;
  logic               WREADY;
  logic [WIDTH-1:0]   WDATA;
  logic [WIDTH/8-1:0] WSTRB;
  logic               BVALID;
  logic               BREADY;
  logic [1:0]         BRESP;
  logic               ARVALID;
  logic               ARREADY;
  logic [WIDTH-1:0]   ARADDR;
  logic               RVALID;
  logic               RREADY;
  logic [WIDTH-1:0]   RDATA;
  logic [1:0]         RRESP;

  modport master (
    output AWVALID, AWADDR, WVALID, WDATA, WSTRB, BREADY, ARVALID, ARADDR, RREADY,
    input  AWREADY, WREADY, BVALID, BRESP, ARREADY, RVALID, RDATA, RRESP
  );

  modport slave (
    input  AWVALID, AWADDR, WVALID, WDATA, WSTRB, BREADY, ARVALID, ARADDR, RREADY,
    output AWREADY, WREADY, BVALID, BRESP, ARREADY, RVALID, RDATA, RRESP
  );

endinterface

// File: rtl/axil_reg_array.sv
// 16 x WIDTH register storage. Register 0 reads a constant ID; 1..15 are
// byte-strobed writable and clear on synchronous active-low reset.
// Ports: clk_i, rst_n_i, we_i/widx_i/wdata_i/wstrb_i (write port),
//        ridx_i/rdata_c_o (combinational read port).
module axil_reg_array
  import axil_pkg::*;
#(
  parameter int unsigned      WIDTH    = 32,
  parameter logic [WIDTH-1:0] ID_VALUE = 32'h4E45_0001
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  we_i,
  input  logic [AXIL_IDX_W-1:0] widx_i,
  input  logic [WIDTH-1:0]      wdata_i,
  input  logic [WIDTH/8-1:0]    wstrb_i,
  input  logic [AXIL_IDX_W-1:0] ridx_i,
  output logic [WIDTH-1:0]      rdata_c_o
);

  logic [WIDTH-1:0] regs_q [AXIL_NUM_REGS];

  // Byte-lane write; index 0 is read-only so its slot is never written.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < int'(AXIL_NUM_REGS); i++) begin
        regs_q[i] <= '0;
      end
    end else if (we_i && (widx_i != '0)) begin
      for (int b = 0; b < int'(WIDTH / 8); b++) begin
        if (wstrb_i[b]) begin
          regs_q[widx_i][8*b +: 8] <= wdata_i[8*b +: 8];
        end
      end
    end
  end

  assign rdata_c_o = (ridx_i == '0) ? ID_VALUE : regs_q[ridx_i];

endmodule

// File: rtl/axil_reg_slave.sv
// AXI4-Lite slave terminating AW/W/B/AR/R into a 16-register bank.
// Ports: ACLK, ARESETn (sync, active-low), s_axil (axil_reg_slave_if.slave).
// Option: define AXIL_SLV_ERR_EN to answer SLVERR for addresses outside the
// 64-byte window at BASE_ADDR; otherwise the bank aliases and always OKAYs.
module axil_reg_slave
  import axil_pkg::*;
#(
  parameter int unsigned      WIDTH     = 32,
  parameter logic [WIDTH-1:0] BASE_ADDR = 32'h0000_1000,
  parameter logic [WIDTH-1:0] ID_VALUE  = 32'h4E45_0001
) (
  input  logic            ACLK,
  input  logic            ARESETn,
  axil_reg_slave_if.slave s_axil
);

  localparam int unsigned STRB_W = WIDTH / 8;

  wr_state_e         wr_state_q, wr_state_d;
  rd_state_e         rd_state_q, rd_state_d;
  logic              awready_q, awready_d;
  logic              wready_q, wready_d;
  logic              bvalid_q, bvalid_d;
  axil_resp_t        bresp_q, bresp_d;
  logic              arready_q, arready_d;
  logic              rvalid_q, rvalid_d;
  axil_resp_t        rresp_q, rresp_d;
  logic [WIDTH-1:0]  rdata_q, rdata_d;
  logic [WIDTH-1:0]  awaddr_q, awaddr_d;
  logic [WIDTH-1:0]  wdata_q, wdata_d;
  logic [STRB_W-1:0] wstrb_q, wstrb_d;

  logic              aw_hs_c, w_hs_c, ar_hs_c;
  logic [WIDTH-1:0]  wr_addr_c, wr_data_c, arr_rdata_c;
  logic [STRB_W-1:0] wr_strb_c;
  logic              wr_err_c, rd_err_c, we_c;
  logic              unused_lsb;

  assign aw_hs_c = s_axil.AWVALID & awready_q;
  assign w_hs_c  = s_axil.WVALID  & wready_q;
  assign ar_hs_c = s_axil.ARVALID & arready_q;

  // Commit uses whichever half arrives this cycle, else the held copy.
  assign wr_addr_c = aw_hs_c ? s_axil.AWADDR : awaddr_q;
  assign wr_data_c = w_hs_c  ? s_axil.WDATA  : wdata_q;
  assign wr_strb_c = w_hs_c  ? s_axil.WSTRB  : wstrb_q;

  assign unused_lsb = ^{wr_addr_c[1:0], s_axil.ARADDR[1:0]};

`ifdef AXIL_SLV_ERR_EN
  assign wr_err_c = (wr_addr_c[WIDTH-1:6] != BASE_ADDR[WIDTH-1:6]);
  assign rd_err_c = (s_axil.ARADDR[WIDTH-1:6] != BASE_ADDR[WIDTH-1:6]);
`else
  logic unused_msb;
  assign unused_msb = ^{wr_addr_c[WIDTH-1:6], s_axil.ARADDR[WIDTH-1:6], BASE_ADDR[WIDTH-1:6]};
  assign wr_err_c   = 1'b0;
  assign rd_err_c   = 1'b0;
`endif

  // Register update on the edge that enters WR_RESP.
  assign we_c = (wr_state_d == WR_RESP) && (wr_state_q != WR_RESP) && !wr_err_c;

  axil_reg_array #(
    .WIDTH    (WIDTH),
    .ID_VALUE (ID_VALUE)
  ) u_regs (
    .clk_i     (ACLK),
    .rst_n_i   (ARESETn),
    .we_i      (we_c),
    .widx_i    (wr_addr_c[5:2]),
    .wdata_i   (wr_data_c),
    .wstrb_i   (wr_strb_c),
    .ridx_i    (s_axil.ARADDR[5:2]),
    .rdata_c_o (arr_rdata_c)
  );

  // Write channel next-state and registered outputs.
  always_comb begin
    wr_state_d = wr_state_q;
    awaddr_d   = awaddr_q;
    wdata_d    = wdata_q;
    wstrb_d    = wstrb_q;
    bresp_d    = bresp_q;
    case (wr_state_q)
      WR_IDLE: begin
        if (aw_hs_c && w_hs_c) wr_state_d = WR_RESP;
        else if (aw_hs_c)      wr_state_d = WR_ADDR;
        else if (w_hs_c)       wr_state_d = WR_DATA;
      end
      WR_ADDR: if (w_hs_c)                     wr_state_d = WR_RESP;
      WR_DATA: if (aw_hs_c)                    wr_state_d = WR_RESP;
      WR_RESP: if (bvalid_q && s_axil.BREADY)  wr_state_d = WR_IDLE;
      default: wr_state_d = WR_IDLE;
    endcase
    if (aw_hs_c) awaddr_d = s_axil.AWADDR;
    if (w_hs_c) begin
      wdata_d = s_axil.WDATA;
      wstrb_d = s_axil.WSTRB;
    end
    if ((wr_state_d == WR_RESP) && (wr_state_q != WR_RESP)) begin
      bresp_d = wr_err_c ? RESP_SLVERR : RESP_OKAY;
    end
    awready_d = (wr_state_d == WR_IDLE) || (wr_state_d == WR_DATA);
    wready_d  = (wr_state_d == WR_IDLE) || (wr_state_d == WR_ADDR);
    bvalid_d  = (wr_state_d == WR_RESP);
  end

  // Read channel next-state; data is captured at the AR handshake.
  always_comb begin
    rd_state_d = rd_state_q;
    rdata_d    = rdata_q;
    rresp_d    = rresp_q;
    case (rd_state_q)
      RD_IDLE: begin
        if (ar_hs_c) begin
          rd_state_d = RD_DATA;
          rdata_d    = rd_err_c ? '0 : arr_rdata_c;
          rresp_d    = rd_err_c ? RESP_SLVERR : RESP_OKAY;
        end
      end
      RD_DATA: if (rvalid_q && s_axil.RREADY) rd_state_d = RD_IDLE;
      default: rd_state_d = RD_IDLE;
    endcase
    arready_d = (rd_state_d == RD_IDLE);
    rvalid_d  = (rd_state_d == RD_DATA);
  end

  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      wr_state_q <= WR_IDLE;
      rd_state_q <= RD_IDLE;
      awready_q  <= 1'b0;
      wready_q   <= 1'b0;
      bvalid_q   <= 1'b0;
      bresp_q    <= RESP_OKAY;
      arready_q  <= 1'b0;
      rvalid_q   <= 1'b0;
      rresp_q    <= RESP_OKAY;
      rdata_q    <= '0;
      awaddr_q   <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
    end else begin
      wr_state_q <= wr_state_d;
      rd_state_q <= rd_state_d;
      awready_q  <= awready_d;
      wready_q   <= wready_d;
      bvalid_q   <= bvalid_d;
      bresp_q    <= bresp_d;
      arready_q  <= arready_d;
      rvalid_q   <= rvalid_d;
      rresp_q    <= rresp_d;
      rdata_q    <= rdata_d;
      awaddr_q   <= awaddr_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
    end
  end

  assign s_axil.AWREADY = awready_q;
  assign s_axil.WREADY  = wready_q;
  assign s_axil.BVALID  = bvalid_q;
  assign s_axil.BRESP   = bresp_q;
  assign s_axil.ARREADY = arready_q;
  assign s_axil.RVALID  = rvalid_q;
  assign s_axil.RDATA   = rdata_q;
  assign s_axil.RRESP   = rresp_q;

endmodule

// File: tb/tb_axil_reg_slave.sv
// Directed + randomized bench for axil_reg_slave against an array model.
module tb_axil_reg_slave;

  localparam logic [31:0] BASE = 32'h0000_1000;
  localparam logic [31:0] IDV  = 32'h4E45_0001;

  logic ACLK    = 1'b0;
  logic ARESETn = 1'b0;

  axil_reg_slave_if #(.WIDTH(32)) bus ();

  axil_reg_slave #(
    .WIDTH     (32),
    .BASE_ADDR (BASE),
    .ID_VALUE  (IDV)
  ) dut (
    .ACLK    (ACLK),
    .ARESETn (ARESETn),
    .s_axil  (bus)
  );

  always #5 ACLK = ~ACLK;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] model [16];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  function automatic bit m_err(input logic [31:0] a);
`ifdef AXIL_SLV_ERR_EN
    return (a / 64) != (BASE / 64);
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [1:0] m_resp(input logic [31:0] a);
    return m_err(a) ? 2'b10 : 2'b00;
  endfunction

  function automatic int m_idx(input logic [31:0] a);
    return int'((a % 64) / 4);
  endfunction

  task automatic m_reset();
    model[0] = IDV;
    for (int i = 1; i < 16; i++) model[i] = 32'h0;
  endtask

  task automatic m_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    int          idx;
    logic [31:0] mask;
    idx = m_idx(a);
    if (!m_err(a) && idx != 0) begin
      mask = 32'h0;
      for (int b = 0; b < 4; b++) if (s[b]) mask = mask | (32'hFF << (8 * b));
      model[idx] = (model[idx] & ~mask) | (d & mask);
    end
  endtask

  function automatic logic [31:0] m_read(input logic [31:0] a);
    return m_err(a) ? 32'h0 : model[m_idx(a)];
  endfunction

  // mode 0: AW and W together; 1: AW leads by gap; 2: W leads by gap.
  task automatic do_write(input string tag, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] s, input int mode, input int gap, input int bdelay);
    int aw_at, w_at, cnt;
    bit aw_done, w_done, aw_now, w_now;
    aw_at = (mode == 2) ? gap : 0;
    w_at  = (mode == 1) ? gap : 0;
    bus.AWADDR = a;
    bus.WDATA  = d;
    bus.WSTRB  = s;
    aw_done = 0; w_done = 0; cnt = 0;
    while (!(aw_done && w_done) && cnt < 40) begin
      if (!aw_done && cnt >= aw_at) bus.AWVALID = 1'b1;
      if (!w_done && cnt >= w_at)   bus.WVALID  = 1'b1;
      aw_now = bus.AWVALID && bus.AWREADY;
      w_now  = bus.WVALID && bus.WREADY;
      tick();
      if (aw_now) begin aw_done = 1; bus.AWVALID = 1'b0; end
      if (w_now)  begin w_done  = 1; bus.WVALID  = 1'b0; end
      if (!(aw_done && w_done)) chk({tag, "/bvalid_early"}, 32'(bus.BVALID), 32'h0);
      cnt++;
    end
    bus.AWVALID = 1'b0;
    bus.WVALID  = 1'b0;
    chk({tag, "/hs_timeout"}, 32'(aw_done && w_done), 32'h1);
    chk({tag, "/bvalid"}, 32'(bus.BVALID), 32'h1);
    chk({tag, "/bresp"}, 32'(bus.BRESP), 32'(m_resp(a)));
    m_write(a, d, s);
    for (int i = 0; i < bdelay; i++) begin
      tick();
      chk({tag, "/bvalid_hold"}, 32'({bus.BVALID, bus.BRESP, bus.AWREADY, bus.WREADY}),
          32'({1'b1, m_resp(a), 2'b00}));
    end
    bus.BREADY = 1'b1;
    tick();
    bus.BREADY = 1'b0;
    chk({tag, "/b_done"}, 32'({bus.BVALID, bus.AWREADY, bus.WREADY}), 32'b011);
  endtask

  task automatic do_read(input string tag, input logic [31:0] a, input int rdelay);
    int          cnt;
    logic [31:0] exp_d;
    bus.ARADDR  = a;
    bus.ARVALID = 1'b1;
    cnt = 0;
    while (!bus.ARREADY && cnt < 40) begin
      tick();
      cnt++;
    end
    exp_d = m_read(a);
    tick();
    bus.ARVALID = 1'b0;
    chk({tag, "/ar_timeout"}, 32'(cnt < 40), 32'h1);
    chk({tag, "/rvalid"}, 32'({bus.RVALID, bus.ARREADY}), 32'b10);
    chk({tag, "/rdata"}, bus.RDATA, exp_d);
    chk({tag, "/rresp"}, 32'(bus.RRESP), 32'(m_resp(a)));
    for (int i = 0; i < rdelay; i++) begin
      tick();
      chk({tag, "/r_hold"}, bus.RDATA, exp_d);
      chk({tag, "/rvalid_hold"}, 32'({bus.RVALID, bus.ARREADY}), 32'b10);
    end
    bus.RREADY = 1'b1;
    tick();
    bus.RREADY = 1'b0;
    chk({tag, "/r_done"}, 32'({bus.RVALID, bus.ARREADY}), 32'b01);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] exp_r, a, d;
    logic [3:0]  s;

    bus.AWVALID = 0; bus.AWADDR = 0; bus.WVALID = 0; bus.WDATA = 0; bus.WSTRB = 0;
    bus.BREADY  = 0; bus.ARVALID = 0; bus.ARADDR = 0; bus.RREADY = 0;
    m_reset();

    // Reset values, then readys rise on the first edge after release.
    repeat (3) tick();
    chk("reset/outs", 32'({bus.AWREADY, bus.WREADY, bus.ARREADY, bus.BVALID, bus.RVALID,
                           bus.BRESP, bus.RRESP}), 32'h0);
    chk("reset/rdata", bus.RDATA, 32'h0);
    ARESETn = 1'b1;
    chk("reset/ready_pre", 32'({bus.AWREADY, bus.WREADY, bus.ARREADY}), 32'b000);
    tick();
    chk("reset/ready_post", 32'({bus.AWREADY, bus.WREADY, bus.ARREADY}), 32'b111);

    do_read("id", BASE + 32'h00, 0);
    do_read("reg5", BASE + 32'h14, 0);

    do_write("wr_14", BASE + 32'h14, 32'hDEAD_BEEF, 4'hF, 0, 0, 0);
    do_read("rd_14", BASE + 32'h14, 0);

    // W three cycles ahead of AW, strobe 0101 over AABBCCDD.
    do_write("pre_0c", BASE + 32'h0C, 32'hAABB_CCDD, 4'hF, 0, 0, 0);
    do_write("wlead_0c", BASE + 32'h0C, 32'h1122_3344, 4'b0101, 2, 3, 0);
    do_read("rd_0c", BASE + 32'h0C, 0);
    chk("strobe_merge", model[3], 32'hAA22_CC44);

    // Stall B and R for 5 cycles while the master offers new requests.
    bus.AWADDR = BASE + 32'h24; bus.WDATA = 32'h0BAD_F00D; bus.WSTRB = 4'hF;
    bus.ARADDR = BASE + 32'h14;
    bus.AWVALID = 1; bus.WVALID = 1; bus.ARVALID = 1;
    exp_r = m_read(BASE + 32'h14);
    tick();
    m_write(BASE + 32'h24, 32'h0BAD_F00D, 4'hF);
    bus.AWADDR = BASE + 32'h28; bus.WDATA = 32'hFFFF_FFFF; bus.ARADDR = BASE + 32'h2C;
    for (int i = 0; i < 5; i++) begin
      chk("stall/valids", 32'({bus.BVALID, bus.RVALID, bus.BRESP, bus.RRESP}), 32'b110000);
      chk("stall/readys", 32'({bus.AWREADY, bus.WREADY, bus.ARREADY}), 32'b000);
      chk("stall/rdata", bus.RDATA, exp_r);
      tick();
    end
    bus.AWVALID = 0; bus.WVALID = 0; bus.ARVALID = 0;
    bus.BREADY = 1; bus.RREADY = 1;
    tick();
    bus.BREADY = 0; bus.RREADY = 0;
    chk("stall/done", 32'({bus.BVALID, bus.RVALID, bus.AWREADY, bus.WREADY, bus.ARREADY}),
        32'b00111);
    do_read("rd_24", BASE + 32'h24, 0);
    do_read("rd_28", BASE + 32'h28, 0);

    // Read and write commit to register 7 on the same edge.
    bus.AWADDR = BASE + 32'h1C; bus.WDATA = 32'h5; bus.WSTRB = 4'hF;
    bus.ARADDR = BASE + 32'h1C;
    bus.AWVALID = 1; bus.WVALID = 1; bus.ARVALID = 1;
    tick();
    bus.AWVALID = 0; bus.WVALID = 0; bus.ARVALID = 0;
    chk("same_edge/valids", 32'({bus.BVALID, bus.RVALID}), 32'b11);
    chk("same_edge/rdata_old", bus.RDATA, 32'h0);
    m_write(BASE + 32'h1C, 32'h5, 4'hF);
    bus.BREADY = 1; bus.RREADY = 1;
    tick();
    bus.BREADY = 0; bus.RREADY = 0;
    do_read("same_edge/rd_new", BASE + 32'h1C, 0);

    // Out-of-window write: SLVERR with the option, alias onto register 1 without.
    do_write("oow_wr", 32'h0000_2004, 32'h1, 4'hF, 0, 0, 1);
    do_read("oow_rd_reg1", BASE + 32'h04, 0);
    do_read("oow_rd", 32'h0000_2004, 1);

    // Register 0 ignores writes.
    do_write("wr_id", BASE + 32'h00, 32'h1234_5678, 4'hF, 1, 2, 0);
    do_read("rd_id", BASE + 32'h00, 0);

    // Randomized traffic against the model.
    for (int it = 0; it < 40; it++) begin
      a = BASE + 32'($urandom_range(0, 15) * 4 + $urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) a = ($urandom & 32'hFFFF_FFC0) | (a & 32'h3F);
      d = $urandom;
      s = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 1) == 0)
        do_write("rnd_wr", a, d, s, $urandom_range(0, 2), $urandom_range(0, 3),
                 $urandom_range(0, 2));
      else
        do_read("rnd_rd", a, $urandom_range(0, 2));
    end

    // Reset mid-transaction: AW held without W, R pending.
    bus.AWADDR = BASE + 32'h08; bus.ARADDR = BASE + 32'h14;
    bus.AWVALID = 1; bus.ARVALID = 1;
    tick();
    bus.AWVALID = 0; bus.ARVALID = 0;
    ARESETn = 1'b0;
    tick();
    tick();
    chk("midrst/outs", 32'({bus.AWREADY, bus.WREADY, bus.ARREADY, bus.BVALID, bus.RVALID}),
        32'h0);
    ARESETn = 1'b1;
    m_reset();
    tick();
    chk("midrst/ready", 32'({bus.AWREADY, bus.WREADY, bus.ARREADY, bus.BVALID, bus.RVALID}),
        32'b11100);
    do_read("midrst/rd_14", BASE + 32'h14, 0);
    do_read("midrst/rd_1c", BASE + 32'h1C, 0);
    do_write("midrst/wr_08", BASE + 32'h08, 32'hCAFE_0008, 4'b1100, 2, 1, 0);
    do_read("midrst/rd_08", BASE + 32'h08, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
